bcd_rtc_counter: RTL
====================

Name: bcd_rtc_counter

Overview:
- Parametrised successor to the alarm-clock current-time counter: loadable BCD time-of-day counter with optional seconds field, runtime 12/24-hour display mode with PM flag, validated loads with error flag, and rollover strobes for the alarm comparator and display blocks.
- Sits between the tick generator and the alarm/display logic.
- Core time is always held internally as 24-hour BCD. The 12-hour form is a registered display conversion.

Parameters:
- SECONDS_EN, 1: 1 = HH:MM:SS and tick means one second; 0 = HH:MM and tick means one minute.
- RESET_HOUR, 0: core hour after reset, integer 0-23.
- RESET_MIN, 0: core minute after reset, integer 0-59.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- tick  in  1  single-cycle advance pulse.
- enable  in  1  1 = ticks are counted; 0 = ticks are ignored (load still works).
- load  in  1  load request, single cycle.
- new_hr_ms, new_hr_ls, new_min_ms, new_min_ls, new_sec_ms, new_sec_ls  in  4 each  BCD load digits, in the current display format.
- new_pm  in  1  PM qualifier for the load; used only when mode_12h=1.
- mode_12h  in  1  display/load format: 1 = 12-hour, 0 = 24-hour.
- hr_ms, hr_ls, min_ms, min_ls, sec_ms, sec_ls  out  4 each  displayed BCD time, registered.
- pm  out  1  1 when core hour >= 12, in either mode.
- load_err  out  1  one-cycle pulse: load was rejected.
- min_strobe, hr_strobe, day_strobe  out  1 each  one-cycle rollover pulses.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Core is set to RESET_HOUR:RESET_MIN:00.
  - Outputs show that time in 24-hour format; pm = (RESET_HOUR>=12).
  - load_err and all strobes are 0.
  - Reset asserted mid-operation overrides any pending load or tick immediately.
- Core update happens at clock edge N when load or (tick and enable) is sampled high.
- Priority at each edge:
  1. A valid load writes the core; a simultaneous tick is dropped.
  2. An invalid load leaves the core unchanged, pulses load_err, and any simultaneous enabled tick is still processed.
  3. Otherwise an enabled tick advances the core.
- Advance:
  - Seconds go 0-9 / 0-5; minutes go 0-9 / 0-5; hours go 00-23.
  - Every ripple is carried correctly, including 09:59:59->10:00:00, 19:59:59->20:00:00 and 23:59:59->00:00:00.
  - With SECONDS_EN=0 the minute digit is advanced directly by each tick.
- Load validation:
  - Every digit must be <=9; min_ms <=5; sec_ms <=5 (seconds digits are checked only if SECONDS_EN=1).
  - In 24-hour mode the hour must be 00-23.
  - In 12-hour mode the hour must be 01-12.
  - Any failing field rejects the whole load.
- 12-hour load mapping: 12 with new_pm=0 -> 00; 12 with new_pm=1 -> 12; h with new_pm=1 -> h+12; h with new_pm=0 -> h.
- 24-hour loads ignore new_pm.
- With SECONDS_EN=0: new_sec digits are ignored, and sec_ms/sec_ls are constant 0.
- Display conversion, registered (1-cycle latency from the core):
  - 24-hour mode: outputs copy the core.
  - 12-hour mode: core 0 -> 12; 1-11 -> same; 12 -> 12; 13-23 -> h-12.
  - A mode_12h change appears on the outputs 1 cycle later; the core is unaffected.
- Timing:
  - A core change at edge N is visible on the outputs after edge N+1.
  - load_err and the strobes are asserted for exactly the cycle following edge N+1, aligned with the display update.
- Strobes (tick-caused only; loads never fire strobes):
  - min_strobe fires when seconds wrap 59->00, or on every tick when SECONDS_EN=0.
  - hr_strobe fires when minutes wrap 59->00.
  - day_strobe fires on 23:59(:59)->00:00(:00).
  - These are cumulative: a day wrap also fires hr_strobe and min_strobe.
- Back-to-back ticks on consecutive cycles are each counted.

Test Plan:
- Release reset with defaults, no tick -> outputs 00:00:00, pm=0; load 23:59:59 (24h) then one tick -> 00:00:00 with day_strobe, hr_strobe and min_strobe high for one cycle.
- Load 09:59:59 then tick -> 10:00:00, hr_strobe=1; load 19:59:59 then tick -> 20:00:00.
- mode_12h=1, core 13:05:00 -> display 01:05:00, pm=1; core 00:30:00 -> 12:30:00, pm=0; toggle mode to 0 -> 00:30:00 one cycle later.
- 12-hour load 12:00:00 with new_pm=0 -> core 00:00; 24-hour load 24:00:00 -> load_err pulse, time unchanged; load 12:60:00 -> load_err.
- Invalid load plus tick in the same cycle on 10:00:05 -> load_err=1 and time 10:00:06; valid load 08:00:00 plus tick -> exactly 08:00:00.
- SECONDS_EN=0 build: tick at 00:59 -> 01:00 with hr_strobe and min_strobe; enable=0 plus tick -> no change; reset_n low mid-load -> RESET_HOUR:RESET_MIN immediately.

Source files
------------

// File: rtl/bcd_rtc_counter_if.sv
// Signal bundle between the tick/load source and the RTC time counter.
// The master drives ticks, loads and the display mode; the slave returns display digits and strobes.
interface bcd_rtc_counter_if;
  logic       tick;
  logic       enable;
  logic       load;
  logic [3:0] new_hr_ms;
  logic [3:0] new_hr_ls;
  logic [3:0] new_min_ms;
  logic [3:0] new_min_ls;
  logic [3:0] new_sec_ms;
  logic [3:0] new_sec_ls;
  logic       new_pm;
  logic       mode_12h;
  logic [3:0] hr_ms;
  logic [3:0] hr_ls;
  logic [3:0] min_ms;
  logic [3:0] min_ls;
  logic [3:0] sec_ms;
  logic [3:0] sec_ls;
  logic       pm;
  logic       load_err;
  logic       min_strobe;
  logic       hr_strobe;
  logic       day_strobe;

  modport master (
    output tick, enable, load,
    output new_hr_ms, new_hr_ls, new_min_ms, new_min_ls, new_sec_ms, new_sec_ls,
    output new_pm, mode_12h,
    input  hr_ms, hr_ls, min_ms, min_ls, sec_ms, sec_ls,
    input  pm, load_err, min_strobe, hr_strobe, day_strobe
  );

  modport slave (
    input  tick, enable, load,
    input  new_hr_ms, new_hr_ls, new_min_ms, new_min_ls, new_sec_ms, new_sec_ls,
    input  new_pm, mode_12h,
    output hr_ms, hr_ls, min_ms, min_ls, sec_ms, sec_ls,
    output pm, load_err, min_strobe, hr_strobe, day_strobe
  );
endinterface

// File: rtl/bcd_rtc_counter.sv
// Loadable BCD time-of-day counter: 24-hour BCD core, registered 12/24-hour display,
// validated loads with an error pulse, and tick-driven rollover strobes.
module bcd_rtc_counter #(
  parameter int unsigned SECONDS_EN = 1,
  parameter int unsigned RESET_HOUR = 0,
  parameter int unsigned RESET_MIN  = 0
) (
  input logic              clk,
  input logic              reset_n,
  bcd_rtc_counter_if.slave rtc
);

  localparam bit         SEC_ON    = (SECONDS_EN != 0);
  localparam logic [3:0] RST_HR_T  = 4'(RESET_HOUR / 10);
  localparam logic [3:0] RST_HR_U  = 4'(RESET_HOUR % 10);
  localparam logic [3:0] RST_MIN_T = 4'(RESET_MIN / 10);
  localparam logic [3:0] RST_MIN_U = 4'(RESET_MIN % 10);
  localparam logic       RST_PM    = (RESET_HOUR >= 12);

  function automatic logic [7:0] bcd2bin8(input logic [3:0] t, input logic [3:0] u);
    return 8'(t) * 8'd10 + 8'(u);
  endfunction

  function automatic logic [4:0] hr_bin5(input logic [3:0] t, input logic [3:0] u);
    return 5'(t) * 5'd10 + 5'(u);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [4:0] h);
    if (h >= 5'd20) return {4'd2, 4'(h - 5'd20)};
    if (h >= 5'd10) return {4'd1, 4'(h - 5'd10)};
    return {4'd0, 4'(h)};
  endfunction

  // Core time, always 24-hour BCD
  logic [3:0] r_hr_t, r_hr_u, r_min_t, r_min_u, r_sec_t, r_sec_u;

  // Stage-1 event flags, re-registered so they line up with the display update
  logic r_err_s1, r_min_stb_s1, r_hr_stb_s1, r_day_stb_s1;

  // Display and strobe output registers
  logic [3:0] r_hr_ms, r_hr_ls, r_min_ms, r_min_ls, r_sec_ms, r_sec_ls;
  logic       r_pm, r_load_err, r_min_stb, r_hr_stb, r_day_stb;

  logic       w_tick_en;
  logic       w_dig_ok;
  logic       w_hr_ok;
  logic       w_ld_valid;
  logic       w_ld_accept;
  logic       w_tick_adv;
  logic [7:0] w_ld_hr_bin;
  logic [4:0] w_ld_hr24;
  logic [7:0] w_ld_hr_bcd;

  logic       w_sec_wrap, w_min_wrap, w_day_wrap;
  logic [3:0] w_nx_hr_t, w_nx_hr_u, w_nx_min_t, w_nx_min_u, w_nx_sec_t, w_nx_sec_u;

  logic [4:0] w_core_hr;
  logic [4:0] w_disp_hr;
  logic [7:0] w_disp_hr_bcd;

  assign w_tick_en = rtc.tick & rtc.enable;

  // Load validation; hour range depends on the format the load is expressed in
  assign w_dig_ok = (rtc.new_hr_ms  <= 4'd9) && (rtc.new_hr_ls  <= 4'd9) &&
                    (rtc.new_min_ms <= 4'd5) && (rtc.new_min_ls <= 4'd9) &&
                    (!SEC_ON || ((rtc.new_sec_ms <= 4'd5) && (rtc.new_sec_ls <= 4'd9)));

  assign w_ld_hr_bin = bcd2bin8(rtc.new_hr_ms, rtc.new_hr_ls);

  assign w_hr_ok = rtc.mode_12h ? ((w_ld_hr_bin >= 8'd1) && (w_ld_hr_bin <= 8'd12))
                                : (w_ld_hr_bin <= 8'd23);

  assign w_ld_valid  = w_dig_ok & w_hr_ok;
  assign w_ld_accept = rtc.load & w_ld_valid;
  assign w_tick_adv  = w_tick_en & ~w_ld_accept;

  always_comb begin
    w_ld_hr24 = w_ld_hr_bin[4:0];
    if (rtc.mode_12h) begin
      if (w_ld_hr_bin == 8'd12) begin
        w_ld_hr24 = rtc.new_pm ? 5'd12 : 5'd0;
      end else if (rtc.new_pm) begin
        w_ld_hr24 = w_ld_hr_bin[4:0] + 5'd12;
      end
    end
  end

  assign w_ld_hr_bcd = bin2bcd(w_ld_hr24);

  // Without a seconds field every tick is a minute, so the seconds wrap is always true
  assign w_sec_wrap = SEC_ON ? ((r_sec_t == 4'd5) && (r_sec_u == 4'd9)) : 1'b1;
  assign w_min_wrap = w_sec_wrap && (r_min_t == 4'd5) && (r_min_u == 4'd9);
  assign w_day_wrap = w_min_wrap && (r_hr_t == 4'd2) && (r_hr_u == 4'd3);

  always_comb begin
    w_nx_sec_t = r_sec_t;
    w_nx_sec_u = r_sec_u;
    w_nx_min_t = r_min_t;
    w_nx_min_u = r_min_u;
    w_nx_hr_t  = r_hr_t;
    w_nx_hr_u  = r_hr_u;

    if (SEC_ON) begin
      if (r_sec_u == 4'd9) begin
        w_nx_sec_u = '0;
        w_nx_sec_t = (r_sec_t == 4'd5) ? '0 : r_sec_t + 4'd1;
      end else begin
        w_nx_sec_u = r_sec_u + 4'd1;
      end
    end

    if (w_sec_wrap) begin
      if (r_min_u == 4'd9) begin
        w_nx_min_u = '0;
        w_nx_min_t = (r_min_t == 4'd5) ? '0 : r_min_t + 4'd1;
      end else begin
        w_nx_min_u = r_min_u + 4'd1;
      end
    end

    if (w_min_wrap) begin
      if (w_day_wrap) begin
        w_nx_hr_t = '0;
        w_nx_hr_u = '0;
      end else if (r_hr_u == 4'd9) begin
        w_nx_hr_u = '0;
        w_nx_hr_t = r_hr_t + 4'd1;
      end else begin
        w_nx_hr_u = r_hr_u + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hr_t  <= RST_HR_T;
      r_hr_u  <= RST_HR_U;
      r_min_t <= RST_MIN_T;
      r_min_u <= RST_MIN_U;
      r_sec_t <= '0;
      r_sec_u <= '0;
    end else if (w_ld_accept) begin
      r_hr_t  <= w_ld_hr_bcd[7:4];
      r_hr_u  <= w_ld_hr_bcd[3:0];
      r_min_t <= rtc.new_min_ms;
      r_min_u <= rtc.new_min_ls;
      r_sec_t <= SEC_ON ? rtc.new_sec_ms : '0;
      r_sec_u <= SEC_ON ? rtc.new_sec_ls : '0;
    end else if (w_tick_en) begin
      r_hr_t  <= w_nx_hr_t;
      r_hr_u  <= w_nx_hr_u;
      r_min_t <= w_nx_min_t;
      r_min_u <= w_nx_min_u;
      r_sec_t <= w_nx_sec_t;
      r_sec_u <= w_nx_sec_u;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_s1     <= 1'b0;
      r_min_stb_s1 <= 1'b0;
      r_hr_stb_s1  <= 1'b0;
      r_day_stb_s1 <= 1'b0;
    end else begin
      r_err_s1     <= rtc.load & ~w_ld_valid;
      r_min_stb_s1 <= w_tick_adv & w_sec_wrap;
      r_hr_stb_s1  <= w_tick_adv & w_min_wrap;
      r_day_stb_s1 <= w_tick_adv & w_day_wrap;
    end
  end

  assign w_core_hr = hr_bin5(r_hr_t, r_hr_u);

  always_comb begin
    w_disp_hr = w_core_hr;
    if (rtc.mode_12h) begin
      if (w_core_hr == 5'd0) begin
        w_disp_hr = 5'd12;
      end else if (w_core_hr > 5'd12) begin
        w_disp_hr = w_core_hr - 5'd12;
      end
    end
  end

  assign w_disp_hr_bcd = bin2bcd(w_disp_hr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hr_ms    <= RST_HR_T;
      r_hr_ls    <= RST_HR_U;
      r_min_ms   <= RST_MIN_T;
      r_min_ls   <= RST_MIN_U;
      r_sec_ms   <= '0;
      r_sec_ls   <= '0;
      r_pm       <= RST_PM;
      r_load_err <= 1'b0;
      r_min_stb  <= 1'b0;
      r_hr_stb   <= 1'b0;
      r_day_stb  <= 1'b0;
    end else begin
      r_hr_ms    <= w_disp_hr_bcd[7:4];
      r_hr_ls    <= w_disp_hr_bcd[3:0];
      r_min_ms   <= r_min_t;
      r_min_ls   <= r_min_u;
      r_sec_ms   <= r_sec_t;
      r_sec_ls   <= r_sec_u;
      r_pm       <= (w_core_hr >= 5'd12);
      r_load_err <= r_err_s1;
      r_min_stb  <= r_min_stb_s1;
      r_hr_stb   <= r_hr_stb_s1;
      r_day_stb  <= r_day_stb_s1;
    end
  end

  assign rtc.hr_ms      = r_hr_ms;
  assign rtc.hr_ls      = r_hr_ls;
  assign rtc.min_ms     = r_min_ms;
  assign rtc.min_ls     = r_min_ls;
  assign rtc.sec_ms     = r_sec_ms;
  assign rtc.sec_ls     = r_sec_ls;
  assign rtc.pm         = r_pm;
  assign rtc.load_err   = r_load_err;
  assign rtc.min_strobe = r_min_stb;
  assign rtc.hr_strobe  = r_hr_stb;
  assign rtc.day_strobe = r_day_stb;

endmodule
